module_a_link: RTL

//  A-side endpoint of the A<->B link. Buffers local requests, sends each one to module_b
//  on data_to_b (wired to B's data_from_a), then waits for B's reply on data_from_b
//  (wired from B's data_to_a). One request outstanding at a time, with a reply timeout.

---
 rtl/module_a_link_pkg.sv | 14 +
 rtl/module_a_req_fifo.sv | 53 +++++
 rtl/module_a_link.sv | 112 +++++++++++
 3 files changed

// File: rtl/module_a_link_pkg.sv
// Shared defaults for the A-side link endpoint: link widths, buffer depth, reply timeout.
// Also holds the saturating increment used by the stray-reply counter.
package module_a_link_pkg;

  localparam int A_DATA_TO_B_BITWIDTH   = 32;
  localparam int A_DATA_FROM_B_BITWIDTH = 32;
  localparam int A_FIFO_DEPTH           = 4;
  localparam int A_TIMEOUT_CYCLES       = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/module_a_req_fifo.sv
// Generic sync FIFO, no bypass: a write is visible at head one cycle later.
// Backpressure: push is ignored while full; pop is ignored while empty.
module module_a_req_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/module_a_link.sv
// A-side link endpoint: buffers requests, sends one at a time to B, waits for reply or timeout.
// Latency: accept->link word 2 cycles, reply->rsp_valid 1 cycle; req_ready drops when buffer full.
module module_a_link
  import module_a_link_pkg::*;
#(
  parameter int DATA_TO_B_BITWIDTH   = A_DATA_TO_B_BITWIDTH,
  parameter int DATA_FROM_B_BITWIDTH = A_DATA_FROM_B_BITWIDTH,
  parameter int FIFO_DEPTH           = A_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES       = A_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [DATA_TO_B_BITWIDTH-2:0]   req_data,
  output logic                            rsp_valid,
  output logic                            rsp_timeout,
  output logic [DATA_FROM_B_BITWIDTH-2:0] rsp_data,
  output logic [DATA_TO_B_BITWIDTH-1:0]   data_to_b,
  input  logic [DATA_FROM_B_BITWIDTH-1:0] data_from_b,
  output logic                            busy,
  output logic [7:0]                      stray_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                        state;
  logic [TW-1:0]                 timer;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_pop;
  logic [DATA_TO_B_BITWIDTH-2:0] fifo_head;
  logic                          reply_vld;

  assign req_ready = !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign reply_vld = data_from_b[DATA_FROM_B_BITWIDTH-1];

  module_a_req_fifo #(
    .WIDTH (DATA_TO_B_BITWIDTH-1),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (req_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
      data_to_b   <= '0;
      busy        <= 1'b0;
      stray_cnt   <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      data_to_b   <= '0;
      // Replies outside WAIT have no request to match; count and drop them.
      if (reply_vld && state != ST_WAIT) stray_cnt <= sat_inc8(stray_cnt);
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            data_to_b <= {1'b1, fifo_head};
            state     <= ST_SEND;
            busy      <= 1'b1;
          end
        end
        ST_SEND: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A reply in the final cycle is checked first, so it beats the timeout.
          if (reply_vld) begin
            rsp_valid <= 1'b1;
            rsp_data  <= data_from_b[DATA_FROM_B_BITWIDTH-2:0];
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (timer == TW'(TIMEOUT_CYCLES-1)) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
